// File: rtl/hybrid_pkg.sv
// hybrid_pkg: types and constants shared by the hybrid (tournament) branch
// predictor blocks. Meta encoding: USE_GLOBAL/USE_LOCAL is the value of the
// meta predictor's choice bit. entry_t is the default-width queue entry;
// pred_flags_t is the width-independent part, reused by parameterised blocks.
package hybrid_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;

    localparam logic USE_GLOBAL = 1'b1;
    localparam logic USE_LOCAL  = 1'b0;

    typedef struct packed {
        logic g_taken;
        logic l_taken;
        logic use_global;
        logic pred_taken;
    } pred_flags_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  g_taken;
        logic                  l_taken;
        logic                  use_global;
        logic                  pred_taken;
    } entry_t;

    function automatic logic select_dir(logic use_global, logic g_taken, logic l_taken);
        return (use_global == USE_GLOBAL) ? g_taken : l_taken;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: circular buffer of in-flight predictions.
// Ports: CLK/RESET (async active-low), push_i/din_i enqueue, pop_i dequeues
// the head (head_o is the current head, valid while count_o != 0), flush_i
// empties the queue after this cycle's pop and cancels a same-cycle push.
// count_o/full_o are registered occupancy. Full/empty come from the count,
// so the pointers are free to wrap and may be equal in both cases.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        rptr_d  = rptr_q + AW'(do_pop);
        wptr_d  = wptr_q + AW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            // Everything behind the popped head is discarded.
            wptr_d  = rptr_d;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/hybrid_pred_tracker.sv
// hybrid_pred_tracker: selects the final branch direction from global/local
// predictions via the meta choice, queues each prediction in order until it
// resolves, then pulses registered update outputs for the global/local and
// meta tables. A mispredicting resolve flushes every younger entry.
// Ports: CLK/RESET (async active-low); predict side Pred_valid, Pred_addr,
// Use_global, Global_taken, Local_taken -> Pred_taken (combinational), Full;
// resolve side Resolve_valid, Resolve_taken -> Upd_*, Meta_upd_*, Mispredict
// (one-cycle pulses); status Count, sticky Overflow/Underflow.
module hybrid_pred_tracker
    import hybrid_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   Pred_valid,
    input  logic [ADDR_W-1:0]      Pred_addr,
    input  logic                   Use_global,
    input  logic                   Global_taken,
    input  logic                   Local_taken,
    output logic                   Pred_taken,
    output logic                   Full,
    input  logic                   Resolve_valid,
    input  logic                   Resolve_taken,
    output logic                   Upd_valid,
    output logic [ADDR_W-1:0]      Upd_addr,
    output logic                   Upd_taken,
    output logic                   Meta_upd_valid,
    output logic                   Meta_upd_global,
    output logic                   Mispredict,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    output logic                   Underflow
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pred_flags_t       f;
    } slot_t;

    slot_t enq, head;
    logic  pop, mis, disagree;

    logic              upd_valid_q, upd_taken_q, meta_valid_q, meta_global_q, mis_q;
    logic [ADDR_W-1:0] upd_addr_q;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;

    assign Pred_taken = select_dir(Use_global, Global_taken, Local_taken);

    always_comb begin
        enq.addr         = Pred_addr;
        enq.f.g_taken    = Global_taken;
        enq.f.l_taken    = Local_taken;
        enq.f.use_global = Use_global;
        enq.f.pred_taken = Pred_taken;
    end

    assign pop      = Resolve_valid && (Count != '0);
    assign mis      = pop && (head.f.pred_taken != Resolve_taken);
    assign disagree = head.f.g_taken != head.f.l_taken;

    pred_fifo #(.DEPTH(DEPTH), .W($bits(slot_t))) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (Pred_valid),
        .pop_i   (pop),
        .flush_i (mis),
        .din_i   (enq),
        .head_o  (head),
        .count_o (Count),
        .full_o  (Full)
    );

    assign overflow_d  = overflow_q  || (Pred_valid && Full && !pop);
    assign underflow_d = underflow_q || (Resolve_valid && !pop);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            meta_valid_q  <= 1'b0;
            meta_global_q <= 1'b0;
            mis_q         <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            upd_valid_q   <= pop;
            if (pop) upd_addr_q <= head.addr;
            upd_taken_q   <= pop && Resolve_taken;
            meta_valid_q  <= pop && disagree;
            meta_global_q <= pop && disagree && (head.f.g_taken == Resolve_taken);
            mis_q         <= mis;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign Upd_valid       = upd_valid_q;
    assign Upd_addr        = upd_addr_q;
    assign Upd_taken       = upd_taken_q;
    assign Meta_upd_valid  = meta_valid_q;
    assign Meta_upd_global = meta_global_q;
    assign Mispredict      = mis_q;
    assign Overflow        = overflow_q;
    assign Underflow       = underflow_q;

endmodule

// File: tb/tb_hybrid_pred_tracker.sv
module tb_hybrid_pred_tracker;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              CLK = 0, RESET = 0;
    logic              Pred_valid = 0, Use_global = 0, Global_taken = 0, Local_taken = 0;
    logic [ADDR_W-1:0] Pred_addr = '0;
    logic              Resolve_valid = 0, Resolve_taken = 0;
    logic              Pred_taken, Full, Upd_valid, Upd_taken, Meta_upd_valid, Meta_upd_global;
    logic              Mispredict, Overflow, Underflow;
    logic [ADDR_W-1:0] Upd_addr;
    logic [2:0]        Count;

    hybrid_pred_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .Pred_valid(Pred_valid), .Pred_addr(Pred_addr),
        .Use_global(Use_global), .Global_taken(Global_taken), .Local_taken(Local_taken),
        .Pred_taken(Pred_taken), .Full(Full), .Resolve_valid(Resolve_valid),
        .Resolve_taken(Resolve_taken), .Upd_valid(Upd_valid), .Upd_addr(Upd_addr),
        .Upd_taken(Upd_taken), .Meta_upd_valid(Meta_upd_valid),
        .Meta_upd_global(Meta_upd_global), .Mispredict(Mispredict), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0, n_tot = 0;

    // Reference model: a queue of outstanding predictions plus expected outputs.
    typedef struct { logic [ADDR_W-1:0] addr; bit g; bit l; bit ug; } m_t;
    m_t mq[$];
    bit              e_uv, e_ut, e_mv, e_mg, e_mis, e_of, e_uf;
    logic [ADDR_W-1:0] e_ua;

    task automatic set_in(bit pv, logic [ADDR_W-1:0] a, bit ug, bit g, bit l, bit rv, bit rt);
        Pred_valid = pv; Pred_addr = a; Use_global = ug; Global_taken = g; Local_taken = l;
        Resolve_valid = rv; Resolve_taken = rt;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic step();
        bit mis;
        m_t e;
        mis = 0;
        e_uv = 0; e_ut = 0; e_mv = 0; e_mg = 0; e_mis = 0;
        if (Resolve_valid) begin
            if (mq.size() == 0) e_uf = 1;
            else begin
                e = mq.pop_front();
                e_uv = 1; e_ua = e.addr; e_ut = Resolve_taken;
                e_mv = (e.g != e.l);
                e_mg = e_mv && (e.g == Resolve_taken);
                mis = ((e.ug ? e.g : e.l) != Resolve_taken);
                e_mis = mis;
            end
        end
        if (mis) mq.delete();
        else if (Pred_valid) begin
            if (mq.size() < DEPTH) begin
                e.addr = Pred_addr; e.g = Global_taken; e.l = Local_taken; e.ug = Use_global;
                mq.push_back(e);
            end else e_of = 1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic apply_reset();
        RESET = 0;
        set_in(0, '0, 0, 0, 0, 0, 0);
        mq.delete();
        e_uv = 0; e_ut = 0; e_mv = 0; e_mg = 0; e_mis = 0; e_of = 0; e_uf = 0; e_ua = '0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tot++; if (Count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", Count); else n_pass++;
        n_tot++; if ({Full, Upd_valid, Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict, Overflow, Underflow} !== 8'h00)
            $display("FAIL reset_flags got=%b exp=00000000", {Full, Upd_valid, Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict, Overflow, Underflow});
        else n_pass++;
        n_tot++; if (Upd_addr !== '0) $display("FAIL reset_addr got=%h exp=0", Upd_addr); else n_pass++;
        RESET = 1;
        set_in(1, 32'h00400010, 1, 1, 0, 0, 0);
        #1;
        n_tot++; if (Pred_taken !== 1'b1) $display("FAIL reset_pred_taken got=%b exp=1", Pred_taken); else n_pass++;
        step();
        n_tot++; if (Count !== 3'd1) $display("FAIL reset_push_count got=%0d exp=1", Count); else n_pass++;
    endtask

    task automatic test_correct_resolve();
        set_in(0, '0, 0, 0, 0, 1, 1);
        step();
        n_tot++; if (Upd_valid !== 1'b1) $display("FAIL cr_upd_valid got=%b exp=1", Upd_valid); else n_pass++;
        n_tot++; if (Upd_addr !== 32'h00400010) $display("FAIL cr_upd_addr got=%h exp=00400010", Upd_addr); else n_pass++;
        n_tot++; if ({Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict} !== 4'b1110)
            $display("FAIL cr_flags got=%b exp=1110", {Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict}); else n_pass++;
        n_tot++; if (Count !== 3'd0) $display("FAIL cr_count got=%0d exp=0", Count); else n_pass++;
        set_in(0, '0, 0, 0, 0, 0, 0);
        step();
        n_tot++; if ({Upd_valid, Meta_upd_valid} !== 2'b00) $display("FAIL cr_pulse_width got=%b exp=00", {Upd_valid, Meta_upd_valid}); else n_pass++;
        n_tot++; if (Upd_addr !== 32'h00400010) $display("FAIL cr_addr_hold got=%h exp=00400010", Upd_addr); else n_pass++;
    endtask

    task automatic test_agree();
        set_in(1, 32'h00000200, 0, 0, 0, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0, 1, 1);
        step();
        n_tot++; if ({Upd_valid, Mispredict, Meta_upd_valid} !== 3'b110)
            $display("FAIL agree_flags got=%b exp=110", {Upd_valid, Mispredict, Meta_upd_valid}); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h00000300 + 4 * i, 1, 1, 1, 0, 0);
            step();
        end
        n_tot++; if (Count !== 3'd3) $display("FAIL flush_pre_count got=%0d exp=3", Count); else n_pass++;
        set_in(1, 32'h00000310, 1, 1, 1, 1, 0);
        step();
        n_tot++; if ({Mispredict, Upd_valid} !== 2'b11) $display("FAIL flush_mis got=%b exp=11", {Mispredict, Upd_valid}); else n_pass++;
        n_tot++; if (Count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", Count); else n_pass++;
        set_in(0, '0, 0, 0, 0, 0, 0);
        step();
        n_tot++; if ({Count, Mispredict} !== 4'b0000) $display("FAIL flush_after got=%b exp=0000", {Count, Mispredict}); else n_pass++;
    endtask

    task automatic test_full();
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 32'h0; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10c;
        for (int i = 0; i < 4; i++) begin
            set_in(1, addrs[i], 1, 1, 1, 0, 0);
            step();
        end
        n_tot++; if ({Full, Overflow} !== 2'b10) $display("FAIL full_pre got=%b exp=10", {Full, Overflow}); else n_pass++;
        set_in(1, 32'h110, 1, 1, 1, 0, 0);
        step();
        n_tot++; if ({Full, Overflow, Count} !== 5'b11100) $display("FAIL full_overflow got=%b exp=11100", {Full, Overflow, Count}); else n_pass++;
        set_in(1, 32'h114, 1, 1, 1, 1, 1);
        step();
        n_tot++; if ({Full, Overflow, Count, Mispredict} !== 6'b111000) $display("FAIL full_pushpop got=%b exp=111000", {Full, Overflow, Count, Mispredict}); else n_pass++;
        n_tot++; if (Upd_addr !== 32'h0) $display("FAIL full_addr0 got=%h exp=0", Upd_addr); else n_pass++;
        set_in(0, '0, 0, 0, 0, 1, 1);
        step();
        n_tot++; if (Upd_addr !== 32'h104) $display("FAIL full_wrap_addr got=%h exp=104", Upd_addr); else n_pass++;
        n_tot++; if (Count !== 3'd3) $display("FAIL full_wrap_count got=%0d exp=3", Count); else n_pass++;
    endtask

    task automatic test_underflow();
        logic [ADDR_W-1:0] exp_a [3];
        exp_a[0] = 32'h108; exp_a[1] = 32'h10c; exp_a[2] = 32'h114;
        for (int i = 0; i < 3; i++) begin
            set_in(0, '0, 0, 0, 0, 1, 1);
            step();
            n_tot++; if (Upd_addr !== exp_a[i]) $display("FAIL drain_addr%0d got=%h exp=%h", i, Upd_addr, exp_a[i]); else n_pass++;
        end
        n_tot++; if ({Underflow, Count} !== 4'b0000) $display("FAIL uf_pre got=%b exp=0000", {Underflow, Count}); else n_pass++;
        set_in(0, '0, 0, 0, 0, 1, 1);
        step();
        n_tot++; if ({Underflow, Upd_valid, Mispredict} !== 3'b100) $display("FAIL uf_flags got=%b exp=100", {Underflow, Upd_valid, Mispredict}); else n_pass++;
        n_tot++; if (Upd_addr !== 32'h114) $display("FAIL uf_addr_hold got=%h exp=114", Upd_addr); else n_pass++;
    endtask

    task automatic test_random();
        bit pv, ug, g, l, rv, rt;
        logic [ADDR_W-1:0] a;
        apply_reset();
        RESET = 1;
        for (int c = 0; c < 400; c++) begin
            pv = ($urandom_range(0, 99) < 65);
            rv = ($urandom_range(0, 99) < 40);
            ug = $urandom_range(0, 1); g = $urandom_range(0, 1); l = $urandom_range(0, 1);
            rt = ($urandom_range(0, 99) < 80) ? (ug ? g : l) : !(ug ? g : l);
            a = ($urandom_range(0, 9) == 0) ? '0 : $urandom;
            // Resolve outcome is biased toward the queue head's own prediction to keep the queue populated.
            if (mq.size() != 0 && $urandom_range(0, 99) < 85) rt = mq[0].ug ? mq[0].g : mq[0].l;
            set_in(pv, a, ug, g, l, rv, rt);
            #1;
            n_tot++; if (Pred_taken !== (ug ? g : l)) $display("FAIL rnd_pred c=%0d got=%b exp=%b", c, Pred_taken, ug ? g : l); else n_pass++;
            step();
            n_tot++; if (Count !== 3'(mq.size())) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, Count, mq.size()); else n_pass++;
            n_tot++; if (Full !== (mq.size() == DEPTH)) $display("FAIL rnd_full c=%0d got=%b", c, Full); else n_pass++;
            n_tot++; if ({Upd_valid, Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict} !== {e_uv, e_ut, e_mv, e_mg, e_mis})
                $display("FAIL rnd_pulses c=%0d got=%b exp=%b", c, {Upd_valid, Upd_taken, Meta_upd_valid, Meta_upd_global, Mispredict}, {e_uv, e_ut, e_mv, e_mg, e_mis});
            else n_pass++;
            n_tot++; if (Upd_addr !== e_ua) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, Upd_addr, e_ua); else n_pass++;
            n_tot++; if ({Overflow, Underflow} !== {e_of, e_uf}) $display("FAIL rnd_sticky c=%0d got=%b exp=%b", c, {Overflow, Underflow}, {e_of, e_uf}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 32'h00000abc, 1, 0, 1, 0, 0);
        step(); step();
        set_in(0, '0, 0, 0, 0, 1, 0);
        #3 RESET = 0;
        #1;
        n_tot++; if ({Count, Upd_valid, Overflow, Underflow} !== 6'b000000)
            $display("FAIL midrst_async got=%b exp=000000", {Count, Upd_valid, Overflow, Underflow}); else n_pass++;
        apply_reset();
        RESET = 1;
        step();
        n_tot++; if ({Count, Upd_valid, Mispredict} !== 5'b00000) $display("FAIL midrst_after got=%b exp=00000", {Count, Upd_valid, Mispredict}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_correct_resolve();
        test_agree();
        test_flush();
        test_full();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
